// File: rtl/p_alu.sv
// p_alu: shared types and flag positions for the ALU execution pipeline
package p_alu;
    typedef enum logic [3:0] {
        CORE_OP_ADD = 4'd0,
        CORE_OP_AND,
        CORE_OP_XOR,
        CORE_OP_SHL,
        CORE_OP_SHR,
        CORE_OP_ASL,
        CORE_OP_ASR,
        CORE_OP_ROR,
        CORE_OP_INVALID
    } e_core_op;
    typedef enum logic [1:0] {UNARY_ID, UNARY_NOT, UNARY_NEG, UNARY_ZERO} e_unary_op;
    typedef enum logic {SHIFT_LEFT, SHIFT_RIGHT} e_shift_dir;
    typedef struct packed {
        e_shift_dir dir;
        logic [2:0] amount;
    } s_shift;
    typedef struct packed {
        e_core_op  core_op;
        e_unary_op a_unary;
        e_unary_op b_unary;
        s_shift    shift;
        e_unary_op out_unary;
    } s_control;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/m_alu_unary.sv
// m_alu_unary: identity / invert / negate / zero applied to one operand
module m_alu_unary
    import p_alu::*;
#(
    parameter int WIDTH = 32
) (
    input  e_unary_op        i_op,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);
    always_comb begin
        o_y = (i_op == UNARY_ID)  ? i_x :
              (i_op == UNARY_NOT) ? ~i_x :
              (i_op == UNARY_NEG) ? -i_x : '0;
    end
endmodule

// File: rtl/m_alu_exec.sv
// m_alu_exec: two-stage ALU; S1 conditions operands, S2 runs the core op and
// output unary into the result register with valid/ready flow control.
module m_alu_exec
    import p_alu::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  s_control         in_ctrl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_illegal
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0]   w_a_cond, w_b_cond, w_b_shift;
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a, r_s1_b;
    e_core_op           r_s1_op;
    e_unary_op          r_s1_out_unary;
    logic               w_s2_accept;
    logic [SW-1:0]      w_cnt;
    logic [WIDTH:0]     w_sum, w_shl, w_shr, w_asr;
    logic [2*WIDTH-1:0] w_ror;
    logic [WIDTH-1:0]   w_out_mask, w_core, w_final;
    logic               w_asl_v, w_add_v, w_c, w_v, w_illegal;
    logic [3:0]         w_flags;

    m_alu_unary #(.WIDTH(WIDTH)) u_a_unary (.i_op(in_ctrl.a_unary), .i_x(in_a), .o_y(w_a_cond));
    m_alu_unary #(.WIDTH(WIDTH)) u_b_unary (.i_op(in_ctrl.b_unary), .i_x(in_b), .o_y(w_b_cond));

    assign w_b_shift   = (in_ctrl.shift.dir == SHIFT_RIGHT) ? w_b_cond >> in_ctrl.shift.amount
                                                             : w_b_cond << in_ctrl.shift.amount;
    assign w_s2_accept = !out_valid || out_ready;
    assign in_ready    = !r_s1_valid || w_s2_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a         <= w_a_cond;
                r_s1_b         <= w_b_shift;
                r_s1_op        <= in_ctrl.core_op;
                r_s1_out_unary <= in_ctrl.out_unary;
            end
        end
    end

    // Shifts are widened by one bit so the carry falls out of the shifted vector.
    assign w_cnt      = r_s1_b[SW-1:0];
    assign w_sum      = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_shl      = {1'b0, r_s1_a} << w_cnt;
    assign w_shr      = {r_s1_a, 1'b0} >> w_cnt;
    assign w_asr      = $signed({r_s1_a, 1'b0}) >>> w_cnt;
    assign w_ror      = {r_s1_a, r_s1_a} >> w_cnt;
    assign w_out_mask = ~({WIDTH{1'b1}} >> w_cnt);
    assign w_asl_v    = |((r_s1_a ^ {WIDTH{w_shl[WIDTH-1]}}) & w_out_mask);
    assign w_add_v    = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
    assign w_illegal  = r_s1_op > CORE_OP_ROR;

    always_comb begin
        w_core = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (r_s1_op)
            CORE_OP_ADD: begin {w_c, w_core} = w_sum; w_v = w_add_v; end
            CORE_OP_AND: w_core = r_s1_a & r_s1_b;
            CORE_OP_XOR: w_core = r_s1_a ^ r_s1_b;
            CORE_OP_SHL: {w_c, w_core} = w_shl;
            CORE_OP_ASL: begin {w_c, w_core} = w_shl; w_v = w_asl_v; end
            CORE_OP_SHR: {w_core, w_c} = w_shr;
            CORE_OP_ASR: {w_core, w_c} = w_asr;
            CORE_OP_ROR: begin w_core = w_ror[WIDTH-1:0]; w_c = (|w_cnt) && w_ror[WIDTH-1]; end
            default: w_core = '0;
        endcase
    end

    m_alu_unary #(.WIDTH(WIDTH)) u_out_unary (.i_op(r_s1_out_unary), .i_x(w_core), .o_y(w_final));

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = w_final[WIDTH-1];
        w_flags[FLAG_Z] = w_final == '0;
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_V] = w_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            out_illegal <= 1'b0;
        end else if (w_s2_accept) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_result  <= w_illegal ? '0 : w_final;
                out_flags   <= w_illegal ? '0 : w_flags;
                out_illegal <= w_illegal;
            end
        end
    end
endmodule

// File: tb/tb_m_alu_exec.sv
// tb_m_alu_exec: directed stimulus with a reference-model scoreboard for m_alu_exec
module tb_m_alu_exec;
    import p_alu::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    s_control    in_ctrl = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        out_illegal;
    int          n_vec = 0;
    int          n_err = 0;
    logic [36:0] q[$];
    logic        hold = 1'b0;
    logic [36:0] held = '0;

    m_alu_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] un(input e_unary_op op, input logic [31:0] x);
        case (op)
            UNARY_NOT:  return ~x;
            UNARY_NEG:  return 32'd0 - x;
            UNARY_ZERO: return 32'd0;
            default:    return x;
        endcase
    endfunction

    function automatic s_control mk(input e_core_op op, input e_unary_op au, input e_unary_op bu,
                                    input e_shift_dir dir, input logic [2:0] amt, input e_unary_op ou);
        s_control c;
        c.core_op = op; c.a_unary = au; c.b_unary = bu;
        c.shift.dir = dir; c.shift.amount = amt; c.out_unary = ou;
        return c;
    endfunction

    // Reference: {illegal, N, Z, C, V, result}; shifts are stepped one bit at a time.
    function automatic logic [36:0] model(input s_control c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r, f;
        logic        cy, v, ones, zeros;
        longint      s;
        if (c.core_op > CORE_OP_ROR) return {1'b1, 36'd0};
        x = un(c.a_unary, a);
        y = un(c.b_unary, b);
        y = (c.shift.dir == SHIFT_RIGHT) ? (y >> c.shift.amount) : (y << c.shift.amount);
        r = x; cy = 1'b0; v = 1'b0; ones = 1'b0; zeros = 1'b0;
        case (c.core_op)
            CORE_OP_ADD: begin
                r  = x + y;
                cy = (longint'(x) + longint'(y)) > 64'hFFFF_FFFF;
                s  = longint'($signed(x)) + longint'($signed(y));
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            CORE_OP_AND: r = x & y;
            CORE_OP_XOR: r = x ^ y;
            default: begin
                for (int i = 0; i < int'(y[4:0]); i++) begin
                    case (c.core_op)
                        CORE_OP_SHL, CORE_OP_ASL: begin
                            cy = r[31];
                            if (r[31]) ones = 1'b1; else zeros = 1'b1;
                            r = {r[30:0], 1'b0};
                        end
                        CORE_OP_SHR: begin cy = r[0]; r = {1'b0, r[31:1]}; end
                        CORE_OP_ASR: begin cy = r[0]; r = {r[31], r[31:1]}; end
                        default:     begin cy = r[0]; r = {r[0], r[31:1]}; end
                    endcase
                end
                if (c.core_op == CORE_OP_ASL) v = r[31] ? zeros : ones;
            end
        endcase
        f = un(c.out_unary, r);
        return {1'b0, f[31], f == 32'd0, cy, v, f};
    endfunction

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) q.push_back(model(in_ctrl, in_a, in_b));
        if (rst_n && hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'({out_illegal, out_flags, out_result}), 64'(held));
        end
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
            else chk("result", 64'({out_illegal, out_flags, out_result}), 64'(q.pop_front()));
        end
        hold = rst_n && out_valid && !out_ready;
        held = {out_illegal, out_flags, out_result};
    end

    task automatic send(input s_control c, input logic [31:0] a, input logic [31:0] b);
        int k;
        in_ctrl = c; in_a = a; in_b = b; in_valid = 1'b1; k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        chk("accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin @(negedge clk); k++; end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_flags", 64'(out_flags), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1 chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        // Overflowing add with latency observation
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h7FFF_FFFF, 32'd1);
        chk("lat_edge_n", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_edge_n1", 64'(out_valid), 64'd1);
        chk("add_result", 64'(out_result), 64'h8000_0000);
        chk("add_flags", 64'(out_flags), 64'b1001);
        chk("add_illegal", 64'(out_illegal), 64'd0);
        drain();
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_NEG, SHIFT_LEFT, 3'd0, UNARY_ID), 32'd5, 32'd5);
        send(mk(CORE_OP_AND, UNARY_NOT, UNARY_NOT, SHIFT_LEFT, 3'd0, UNARY_NOT), 32'hF0, 32'h0F);
        send(mk(CORE_OP_ASR, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h8000_0000, 32'd4);
        send(mk(CORE_OP_ASL, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h4000_0000, 32'd1);
        send(mk(CORE_OP_INVALID, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h1234, 32'h5678);
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'd1, 32'd2);
        send(mk(CORE_OP_SHL, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h8000_0001, 32'd1);
        send(mk(CORE_OP_SHL, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'hDEAD_BEEF, 32'd32);
        send(mk(CORE_OP_SHR, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h0000_0003, 32'd1);
        send(mk(CORE_OP_ROR, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'h0000_0001, 32'd1);
        send(mk(CORE_OP_ROR, UNARY_ID, UNARY_ID, SHIFT_RIGHT, 3'd1, UNARY_ID), 32'h1234_5678, 32'd17);
        send(mk(CORE_OP_XOR, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_NEG), 32'hFF00_FF00, 32'h0F0F_0F0F);
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd3, UNARY_ID), 32'd2, 32'd1);
        send(mk(CORE_OP_ADD, UNARY_NEG, UNARY_ZERO, SHIFT_LEFT, 3'd7, UNARY_ID), 32'd9, 32'hFFFF_FFFF);
        send(mk(CORE_OP_ASL, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ZERO), 32'hC000_0000, 32'd3);
        send(mk(CORE_OP_ASL, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'hF000_0001, 32'd3);
        drain();
        // Back-to-back with the consumer stalled
        out_ready = 1'b0;
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'd100, 32'd23);
        send(mk(CORE_OP_XOR, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'hAAAA_5555, 32'hFFFF_0000);
        in_ctrl = mk(CORE_OP_SHR, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID);
        in_a = 32'h8000_0000; in_b = 32'd31; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 50) begin @(negedge clk); k++; end
            chk("stall_accept", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        // Reset with both stages full
        out_ready = 1'b0;
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'd7, 32'd8);
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'd9, 32'd10);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(out_result), 64'd0);
        q.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("postrst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("postrst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(mk(CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_LEFT, 3'd0, UNARY_ID), 32'hFFFF_FFFF, 32'd1);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
